mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between the instruction-fetch port and the load/store stage of the 6-stage riscv pipeline.
- Sequences each access as a request/grant/ready transaction.
- Load/store has priority, because it belongs to an older instruction; a starvation counter protects fetch.
- Sits between the core's fetch/LS outputs and the memory model or SRAM wrapper.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/arb_starve_cnt.sv | 26 ++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared bus width, arbiter state encoding and timeout fill data
package riscv_pkg;

  localparam int BUS_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    LS_ACC = 2'd2
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating count of LS grants taken while fetch waits
module arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt >= W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch vs load/store arbiter for one single-ported memory
// Optional watchdog on stalled accesses enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int BUS_WIDTH      = riscv_pkg::BUS_WIDTH,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [BUS_WIDTH-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [BUS_WIDTH-1:0] if_rdata,
  input  logic                 ls_re,
  input  logic                 ls_wr,
  input  logic [BUS_WIDTH-1:0] ls_addr,
  input  logic [BUS_WIDTH-1:0] ls_wdata,
  output logic                 ls_gnt,
  output logic                 ls_rvalid,
  output logic [BUS_WIDTH-1:0] ls_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic [BUS_WIDTH-1:0] mem_rdata,
  output logic                 busy,
  output logic                 err
);

  arb_state_t state, state_next;

  logic ls_req;
  logic starve_hit;
  logic starve_inc;
  logic starve_clr;
  logic timeout;
  logic done;
  logic [BUS_WIDTH-1:0] rdata_in;

  assign ls_req = ls_re | ls_wr;

  arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (starve_hit)
  );

  assign starve_inc = ls_gnt & if_req;
  assign starve_clr = if_gnt | ((state == IDLE) & ~if_req);

`ifdef MEM_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wd_cnt;

  // Counter is held at zero in IDLE, so every access starts from a fresh count.
  always_ff @(posedge clk) begin
    if (!reset || state == IDLE) begin
      wd_cnt <= '0;
    end else if (!mem_ready) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout = (state != IDLE) && !mem_ready && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign done     = mem_ready | timeout;
  assign rdata_in = timeout ? BUS_WIDTH'(TIMEOUT_DATA) : mem_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        if (ls_req && (!if_req || !starve_hit)) begin
          ls_gnt     = 1'b1;
          err        = ls_re & ls_wr;
          state_next = LS_ACC;
        end else if (if_req) begin
          if_gnt     = 1'b1;
          state_next = IF_ACC;
        end
      end
      IF_ACC, LS_ACC: begin
        if (done) begin
          err        = timeout;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Grants are Mealy outputs; keep them quiet while reset is held.
    if (!reset) begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
      err    = 1'b0;
    end
  end

  assign busy    = (state != IDLE);
  assign mem_req = busy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if (if_gnt) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end
      if (ls_gnt) begin
        mem_we    <= ls_wr;
        mem_addr  <= ls_addr;
        mem_wdata <= ls_wdata;
      end
      if (state == IF_ACC && done) begin
        if_rdata  <= rdata_in;
        if_rvalid <= 1'b1;
      end
      // Stores complete with rvalid but leave the last load data in place.
      if (state == LS_ACC && done) begin
        if (!mem_we) begin
          ls_rdata <= rdata_in;
        end
        ls_rvalid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, ls_re, ls_wr, mem_ready;
  logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we, busy, err;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .BUS_WIDTH      (32),
    .STARVE_LIMIT   (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_re     (ls_re),
    .ls_wr     (ls_wr),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err       (err)
  );

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        lre;
    logic        lwr;
    logic [31:0] lsa;
    logic [31:0] wd;
    logic        rdy;
    logic [31:0] rdat;
    logic        ifg;
    logic        lsg;
    logic        ifv;
    logic        lsv;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic        bsy;
    logic        er;
    logic [31:0] ifd;
    logic [31:0] lsd;
  } vec_t;

  vec_t tv [20];

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (step %0d): got %h want %h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input logic ifr, input logic lre, input logic lwr, input logic rdy);
    if_req    = ifr;
    ls_re     = lre;
    ls_wr     = lwr;
    mem_ready = rdy;
  endtask

  initial begin
    // ifr ifa lre lwr lsa wd rdy rdat | ifg lsg ifv lsv mreq mwe maddr mwd busy err ifd lsd
    tv[0]  = '{H, 32'h10, L, L, 32'h0,  32'h0,        L, 32'h0,        H, L, L, L, L, L, 32'h0,  32'h0,        L, L, 32'h0,        32'h0};
    tv[1]  = '{L, 32'h0,  L, L, 32'h0,  32'h0,        L, 32'h0,        L, L, L, L, H, L, 32'h10, 32'h0,        H, L, 32'h0,        32'h0};
    tv[2]  = '{L, 32'h0,  L, L, 32'h0,  32'h0,        H, 32'h00500093, L, L, L, L, H, L, 32'h10, 32'h0,        H, L, 32'h0,        32'h0};
    tv[3]  = '{L, 32'h0,  L, L, 32'h0,  32'h0,        L, 32'h0,        L, L, H, L, L, L, 32'h10, 32'h0,        L, L, 32'h00500093, 32'h0};
    tv[4]  = '{L, 32'h0,  L, H, 32'h20, 32'hCAFE0001, L, 32'h0,        L, H, L, L, L, L, 32'h10, 32'h0,        L, L, 32'h00500093, 32'h0};
    tv[5]  = '{L, 32'h0,  L, L, 32'h0,  32'h0,        L, 32'h0,        L, L, L, L, H, H, 32'h20, 32'hCAFE0001, H, L, 32'h00500093, 32'h0};
    tv[6]  = '{L, 32'h0,  L, L, 32'h0,  32'h0,        H, 32'h12345678, L, L, L, L, H, H, 32'h20, 32'hCAFE0001, H, L, 32'h00500093, 32'h0};
    tv[7]  = '{L, 32'h0,  L, L, 32'h0,  32'h0,        L, 32'h0,        L, L, L, H, L, H, 32'h20, 32'hCAFE0001, L, L, 32'h00500093, 32'h0};
    tv[8]  = '{L, 32'h0,  H, L, 32'h44, 32'h0,        L, 32'h0,        L, H, L, L, L, H, 32'h20, 32'hCAFE0001, L, L, 32'h00500093, 32'h0};
    tv[9]  = '{L, 32'h0,  L, L, 32'h0,  32'h0,        H, 32'hABCD0004, L, L, L, L, H, L, 32'h44, 32'h0,        H, L, 32'h00500093, 32'h0};
    tv[10] = '{L, 32'h0,  L, L, 32'h0,  32'h0,        L, 32'h0,        L, L, L, H, L, L, 32'h44, 32'h0,        L, L, 32'h00500093, 32'hABCD0004};
    tv[11] = '{L, 32'h0,  L, L, 32'h0,  32'h0,        H, 32'hFFFFFFFF, L, L, L, L, L, L, 32'h44, 32'h0,        L, L, 32'h00500093, 32'hABCD0004};
    tv[12] = '{H, 32'h30, H, L, 32'h40, 32'h0,        L, 32'h0,        L, H, L, L, L, L, 32'h44, 32'h0,        L, L, 32'h00500093, 32'hABCD0004};
    tv[13] = '{H, 32'h30, L, L, 32'h0,  32'h0,        H, 32'h11110040, L, L, L, L, H, L, 32'h40, 32'h0,        H, L, 32'h00500093, 32'hABCD0004};
    tv[14] = '{H, 32'h30, L, L, 32'h0,  32'h0,        L, 32'h0,        H, L, L, H, L, L, 32'h40, 32'h0,        L, L, 32'h00500093, 32'h11110040};
    tv[15] = '{L, 32'h0,  L, L, 32'h0,  32'h0,        H, 32'h22220030, L, L, L, L, H, L, 32'h30, 32'h0,        H, L, 32'h00500093, 32'h11110040};
    tv[16] = '{L, 32'h0,  L, L, 32'h0,  32'h0,        L, 32'h0,        L, L, H, L, L, L, 32'h30, 32'h0,        L, L, 32'h22220030, 32'h11110040};
    tv[17] = '{L, 32'h0,  H, H, 32'h50, 32'h0BAD0005, L, 32'h0,        L, H, L, L, L, L, 32'h30, 32'h0,        L, H, 32'h22220030, 32'h11110040};
    tv[18] = '{L, 32'h0,  L, L, 32'h0,  32'h0,        H, 32'h33333333, L, L, L, L, H, H, 32'h50, 32'h0BAD0005, H, L, 32'h22220030, 32'h11110040};
    tv[19] = '{L, 32'h0,  L, L, 32'h0,  32'h0,        L, 32'h0,        L, L, L, H, L, H, 32'h50, 32'h0BAD0005, L, L, 32'h22220030, 32'h11110040};

    // Reset held with requests pending: everything must read back zero.
    reset = 1'b0;
    drive(H, H, L, H);
    if_addr = 32'h7; ls_addr = 32'h9; ls_wdata = 32'h5; mem_rdata = 32'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_gnt",   -1, {30'd0, if_gnt, ls_gnt}, 32'h0);
    chk("rst_mem",   -1, {29'd0, mem_req, mem_we, busy}, 32'h0);
    chk("rst_pulse", -1, {29'd0, if_rvalid, ls_rvalid, err}, 32'h0);
    chk("rst_addr",  -1, mem_addr | mem_wdata, 32'h0);
    chk("rst_rdata", -1, if_rdata | ls_rdata, 32'h0);
    reset = 1'b1;
    drive(L, L, L, L);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tv[i].ifr, tv[i].lre, tv[i].lwr, tv[i].rdy);
      if_addr = tv[i].ifa; ls_addr = tv[i].lsa; ls_wdata = tv[i].wd; mem_rdata = tv[i].rdat;
      #1;
      chk("if_gnt",    i, {31'd0, if_gnt},    {31'd0, tv[i].ifg});
      chk("ls_gnt",    i, {31'd0, ls_gnt},    {31'd0, tv[i].lsg});
      chk("if_rvalid", i, {31'd0, if_rvalid}, {31'd0, tv[i].ifv});
      chk("ls_rvalid", i, {31'd0, ls_rvalid}, {31'd0, tv[i].lsv});
      chk("mem_req",   i, {31'd0, mem_req},   {31'd0, tv[i].mreq});
      chk("mem_we",    i, {31'd0, mem_we},    {31'd0, tv[i].mwe});
      chk("mem_addr",  i, mem_addr,           tv[i].maddr);
      chk("mem_wdata", i, mem_wdata,          tv[i].mwd);
      chk("busy",      i, {31'd0, busy},      {31'd0, tv[i].bsy});
      chk("err",       i, {31'd0, err},       {31'd0, tv[i].er});
      chk("if_rdata",  i, if_rdata,           tv[i].ifd);
      chk("ls_rdata",  i, ls_rdata,           tv[i].lsd);
    end

    // Starvation: both requesters held, memory answers at once -> L L L L F L.
    begin
      string seq = "";
      int cyc = 0;
      ls_addr = 32'h60; if_addr = 32'h70;
      while (seq.len() < 6 && cyc < 100) begin
        @(negedge clk);
        drive(H, H, L, mem_req);
        #1;
        if (ls_gnt) seq = {seq, "L"};
        if (if_gnt) seq = {seq, "F"};
        cyc++;
      end
      total++;
      if (seq != "LLLLFL") begin
        bad++;
        $display("FAIL starve_order: got %s want LLLLFL (cycles %0d)", seq, cyc);
      end
    end

    // Drain, then reset in the middle of an LS access.
    @(negedge clk); drive(L, L, L, H);
    repeat (3) @(negedge clk);
    drive(L, H, L, L); ls_addr = 32'h88;
    #1; chk("mid_gnt", 100, {31'd0, ls_gnt}, 32'h1);
    @(negedge clk); drive(L, L, L, L);
    #1; chk("mid_req", 101, {30'd0, mem_req, busy}, 32'h3);
    reset = 1'b0;
    @(negedge clk); reset = 1'b1; drive(L, L, L, H);
    #1; chk("mid_drop", 102, {30'd0, mem_req, busy}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("late_rdy", 103 + k, {29'd0, ls_rvalid, if_rvalid, err}, 32'h0);
    end

`ifdef MEM_TIMEOUT_EN
    begin
      int n = 0;
      @(negedge clk); drive(H, L, L, L); if_addr = 32'h90;
      #1; chk("to_gnt", 200, {31'd0, if_gnt}, 32'h1);
      @(negedge clk); drive(L, L, L, L);
      #1;
      while (!err && n < 20) begin
        @(negedge clk); #1;
        n++;
      end
      chk("to_cycles", 201, n, 32'd7);
      @(negedge clk); #1;
      chk("to_rvalid", 202, {30'd0, if_rvalid, busy}, 32'h2);
      chk("to_rdata",  203, if_rdata, 32'hDEADBEEF);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
